// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared definitions for the matmul sequencer family: the
//               controller state encoding, the index-width helper and the
//               packed-element offset helper. Every matmul datapath variant
//               uses the same packing, with element (0,0) in the MSBs.
// Ports       : none (package)
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width needed to hold the indices 0..n-1. A minimum of one bit keeps the
    // counters legal when n is small.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // LSB position of element (r,c) inside an n x n matrix packed at dw bits
    // per element.
    function automatic int elem_lsb(input int r, input int c, input int n, input int dw);
        return (n * n - 1 - (r * n + c)) * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_mac.sv
`default_nettype none
// ============================================================================
// Module      : matmul_mac
// Description : Combinational multiply-accumulate for the matmul sequencer.
//               sum = (clear ? 0 : acc) + a*b, kept to DW bits.
// Ports       : clear - start a new dot product (ignore acc)
//               acc   - running partial sum, DW bits
//               a, b  - operands, DW bits each
//               sum   - new partial sum, DW bits
//               sat   - sum was clamped (present only with MATMUL_SAT_EN)
// Config      : MATMUL_SAT_EN - clamp the sum to 2^DW-1 instead of wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clear,
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum
`ifdef MATMUL_SAT_EN
    ,
    output logic          sat
`endif
);

    logic [DW-1:0] w_base;

    assign w_base = clear ? '0 : acc;

`ifdef MATMUL_SAT_EN
    // Full-precision sum: a DW-bit base plus a 2*DW-bit product needs one
    // extra bit so the comparison against the limit never overflows.
    localparam logic [2*DW:0] c_sum_max = {{(DW + 1){1'b0}}, {DW{1'b1}}};

    logic [2*DW-1:0] w_prod;
    logic [2*DW:0]   w_wide;

    always_comb begin
        w_prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        w_wide = {{(DW + 1){1'b0}}, w_base} + {1'b0, w_prod};
        sat    = (w_wide > c_sum_max);
        sum    = sat ? {DW{1'b1}} : w_wide[DW-1:0];
    end
`else
    // Only the low DW bits of the product can reach a modulo-2^DW sum.
    logic [DW-1:0] w_prod;

    always_comb begin
        w_prod = a * b;
        sum    = w_base + w_prod;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/matmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matmul_seq_ctrl
// Description : Sequencer for an N x N unsigned matrix multiply Res = A*B on
//               one shared MAC, one product per cycle. A and B are accepted
//               on a valid/ready handshake, i/j/k are walked row-major over
//               N^3 cycles, and Res is returned on a valid/ready handshake.
// Ports       : clk, resetn            - clock, synchronous active-low reset
//               in_valid/in_ready      - A/B handshake
//               A, B                   - packed operands, (0,0) in the MSBs
//               out_valid/out_ready    - Res handshake
//               Res                    - packed result, same packing
//               busy                   - job in RUN or DONE
//               sat_flag               - an element saturated (0 if disabled)
// Config      : MATMUL_SAT_EN - saturating accumulation with sticky sat_flag;
//               undefined: modulo-2^DW wrap, sat_flag tied low
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*N*DW-1:0] A,
    input  logic [N*N*DW-1:0] B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*N*DW-1:0] Res,
    output logic              busy,
    output logic              sat_flag
);

    localparam int                c_iw       = idx_width(N);
    localparam int                c_mw       = N * N * DW;
    localparam logic [c_iw-1:0]   c_last_idx = c_iw'(N - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_last;

    logic [c_mw-1:0]   r_a;
    logic [c_mw-1:0]   r_b;
    logic [c_mw-1:0]   r_res;
    logic [c_iw-1:0]   r_i;
    logic [c_iw-1:0]   r_j;
    logic [c_iw-1:0]   r_k;
    logic [DW-1:0]     r_acc;

    logic [DW-1:0]     w_a_el;
    logic [DW-1:0]     w_b_el;
    logic [DW-1:0]     w_sum;
    logic              w_k_first;

`ifdef MATMUL_SAT_EN
    logic              r_sat;
    logic              w_sat;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The final product of the job is the one with i, j and k all at N-1.
    assign w_last = (r_i == c_last_idx) && (r_j == c_last_idx) && (r_k == c_last_idx);

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // MAC operand selection: A[i][k] and B[k][j]
    // ------------------------------------------------------------------
    assign w_a_el    = r_a[elem_lsb(int'(r_i), int'(r_k), N, DW) +: DW];
    assign w_b_el    = r_b[elem_lsb(int'(r_k), int'(r_j), N, DW) +: DW];
    assign w_k_first = (r_k == '0);

    matmul_mac #(
        .DW (DW)
    ) u_mac (
        .clear (w_k_first),
        .acc   (r_acc),
        .a     (w_a_el),
        .b     (w_b_el),
        .sum   (w_sum)
`ifdef MATMUL_SAT_EN
        ,
        .sat   (w_sat)
`endif
    );

    // ------------------------------------------------------------------
    // Operand, counter, accumulator and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_res <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_acc <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc <= w_sum;
            if (r_k == c_last_idx) begin
                // Dot product complete: commit element (i,j), advance j then i.
                r_res[elem_lsb(int'(r_i), int'(r_j), N, DW) +: DW] <= w_sum;
                r_k <= '0;
                if (r_j == c_last_idx) begin
                    r_j <= '0;
                    r_i <= (r_i == c_last_idx) ? '0 : r_i + c_iw'(1);
                end else begin
                    r_j <= r_j + c_iw'(1);
                end
            end else begin
                r_k <= r_k + c_iw'(1);
            end
        end
    end

`ifdef MATMUL_SAT_EN
    // Sticky across the whole job; only a new accept (or reset) clears it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_sat <= 1'b0;
        end else if ((r_state == ST_RUN) && w_sat) begin
            r_sat <= 1'b1;
        end
    end

    assign sat_flag = r_sat;
`else
    assign sat_flag = 1'b0;
`endif

    assign Res = r_res;

endmodule
`default_nettype wire

// File: tb/tb_matmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_seq_ctrl
// Description : Self-checking bench for matmul_seq_ctrl (N=2, DW=8). Directed
//               table vectors, multi-cycle handshake/reset sequences and
//               random jobs checked against a plain-arithmetic matrix model.
// Config      : MATMUL_SAT_EN - expectations follow the saturating build
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_seq_ctrl;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int MW = N * N * DW;
    localparam int LAT = N * N * N;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] A;
    logic [MW-1:0] B;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] Res;
    logic          busy;
    logic          sat_flag;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    matmul_seq_ctrl #(
        .N  (N),
        .DW (DW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Res       (Res),
        .busy      (busy),
        .sat_flag  (sat_flag)
    );

    typedef struct {
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [MW-1:0] res;
        logic          sat;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int el(input logic [MW-1:0] m, input int r, input int c);
        return int'(m[(N * N - 1 - (r * N + c)) * DW +: DW]);
    endfunction

    // Reference: textbook triple loop on integers, then wrap or clamp.
    task automatic model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                         output logic [MW-1:0] r, output logic s);
        int sum;
        r = '0;
        s = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sum = 0;
                for (int k = 0; k < N; k++) sum += el(a, i, k) * el(b, k, j);
`ifdef MATMUL_SAT_EN
                if (sum > 255) begin
                    sum = 255;
                    s   = 1'b1;
                end
`else
                sum = sum % 256;
`endif
                r[(N * N - 1 - (i * N + j)) * DW +: DW] = 8'(sum);
            end
        end
    endtask

    task automatic run_job(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b,
                           input logic [MW-1:0] exp_r, input logic exp_s);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(LAT));
        chk({tag, " res"}, Res, exp_r);
        chk({tag, " sat"}, 32'(sat_flag), 32'(exp_s));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " post out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " post in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " res held"}, Res, exp_r);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [MW-1:0] er, a1, b1, held;
        logic          es;
        int            n, cyc, last_acc, done_cnt;
        logic          acc_now, hs;
        logic [MW-1:0] q_r[$];
        logic          q_s[$];

        tbl[0] = '{32'h01020304, 32'h05060708, 32'h13162B32, 1'b0};
        tbl[2] = '{32'h01000001, 32'h12345678, 32'h12345678, 1'b0};
        tbl[3] = '{32'h00000000, 32'hAABBCCDD, 32'h00000000, 1'b0};
        tbl[5] = '{32'h0F0F0F0F, 32'h02020202, 32'h3C3C3C3C, 1'b0};
`ifdef MATMUL_SAT_EN
        tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        tbl[4] = '{32'h10101010, 32'h10101010, 32'hFFFFFFFF, 1'b1};
`else
        tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h02020202, 1'b0};
        tbl[4] = '{32'h10101010, 32'h10101010, 32'h00000000, 1'b0};
`endif

        // Reset state
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        tick();
        tick();
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset res", Res, 32'd0);
        chk("reset sat", 32'(sat_flag), 32'd0);
        resetn = 1'b1;
        tick();

        // Directed table
        for (int t = 0; t < 6; t++) begin
            run_job($sformatf("tbl%0d", t), tbl[t].a, tbl[t].b, tbl[t].res, tbl[t].sat);
        end

        // DONE held for 10 cycles with out_ready low
        a1 = 32'h01020304;
        b1 = 32'h05060708;
        A = a1; B = b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        held = Res;
        chk("hold first res", held, 32'h13162B32);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("hold out_valid c%0d", c), 32'(out_valid), 32'd1);
            chk($sformatf("hold res c%0d", c), Res, held);
            chk($sformatf("hold in_ready c%0d", c), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold release out_valid", 32'(out_valid), 32'd0);
        chk("hold release in_ready", 32'(in_ready), 32'd1);
        chk("hold release busy", 32'(busy), 32'd0);

        // in_valid held with changing A/B during RUN; out_ready high while
        // out_valid is low must do nothing
        a1 = $urandom;
        b1 = $urandom;
        model(a1, b1, er, es);
        A = a1; B = b1; in_valid = 1'b1;
        tick();
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            A = $urandom;
            B = $urandom;
            tick();
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("ignore latency", 32'(n), 32'(LAT));
        chk("ignore res", Res, er);
        chk("ignore sat", 32'(sat_flag), 32'(es));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ignore release in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of RUN
        A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst res", Res, 32'd0);
        chk("midrst sat", 32'(sat_flag), 32'd0);
        a1 = $urandom;
        b1 = $urandom;
        model(a1, b1, er, es);
        run_job("after reset", a1, b1, er, es);

        // Random jobs, every other one biased toward large elements
        for (int t = 0; t < 12; t++) begin
            a1 = $urandom;
            b1 = $urandom;
            if (t % 2 == 1) begin
                a1 = a1 | 32'h80808080;
                b1 = b1 | 32'h40404040;
            end
            model(a1, b1, er, es);
            run_job($sformatf("rand%0d", t), a1, b1, er, es);
        end

        // Back-to-back with in_valid and out_ready held high
        q_r.delete();
        q_s.delete();
        last_acc = -1;
        cyc      = 0;
        done_cnt = 0;
        A = $urandom; B = $urandom;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (done_cnt < 5 && cyc < 200) begin
            acc_now = in_ready && in_valid;
            hs      = out_valid && out_ready;
            if (hs) begin
                if (q_r.size() > 0) begin
                    er = q_r.pop_front();
                    es = q_s.pop_front();
                    chk($sformatf("b2b res %0d", done_cnt), Res, er);
                    chk($sformatf("b2b sat %0d", done_cnt), 32'(sat_flag), 32'(es));
                end else begin
                    chk("b2b unexpected out_valid", 32'd1, 32'd0);
                end
                done_cnt++;
            end
            if (acc_now) begin
                model(A, B, er, es);
                q_r.push_back(er);
                q_s.push_back(es);
                if (last_acc >= 0) chk("b2b accept interval", 32'(cyc - last_acc), 32'(LAT + 2));
                last_acc = cyc;
            end
            tick();
            cyc++;
            if (acc_now) begin
                A = $urandom;
                B = $urandom;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b jobs completed", 32'(done_cnt), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
